// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the byte/half lane masks used when merging sub-word stores.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] align_bits(input logic [2:0] f3);
        case (f3[1:0])
            2'b01:   return 2'b01;
            2'b10:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result formatting: picks the addressed byte/half out of a memory
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            byte_off,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte lane and the addressed half lane.
    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        half_sel = word[{byte_off[1], 4'b0000} +: 16];
    end

    // Extend the selected lane to a full word.
    always_comb begin
        case (funct3)
            F3_B:    data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_H:    data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between EX/MEM and a word-wide data memory.
// Sub-word stores are done as read-modify-write over two cycles.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses are rejected with rsp_err; otherwise the address is force-aligned.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  dm_wr_en,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wr_data,
    input  logic [DATA_WIDTH-1:0] dm_rd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    lsu_state_t state, state_next;

    logic                  accept;
    logic                  bad;
    logic                  do_sw;
    logic                  do_rmw;
    logic [1:0]            low_mask;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            byte_off;
    logic [4:0]            lane_shift;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_data;

    logic [DATA_WIDTH-1:0] merge_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign low_mask = align_bits(req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(req_addr[1:0] & low_mask);
    assign eff_addr   = req_addr;
    assign bad        = !f3_legal(req_we, req_funct3) || misaligned;
`else
    assign eff_addr   = {req_addr[ADDR_WIDTH-1:2], req_addr[1:0] & ~low_mask};
    assign bad        = !f3_legal(req_we, req_funct3);
`endif

    assign byte_off   = eff_addr[1:0];
    assign lane_shift = {byte_off, 3'b000};
    assign word_addr  = {eff_addr[ADDR_WIDTH-1:2], 2'b00};

    assign accept = req_valid && (state == IDLE);
    assign do_sw  = accept && req_we && !bad && (req_funct3 == F3_W);
    assign do_rmw = accept && req_we && !bad && (req_funct3 != F3_W);

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .word     (dm_rd_data),
        .byte_off (byte_off),
        .funct3   (req_funct3),
        .data     (load_data)
    );

    // Merge the store lanes into the word read back from memory.
    always_comb begin
        wmask  = ((req_funct3[1:0] == 2'b00) ? DATA_WIDTH'(LANE_MASK_B)
                                            : DATA_WIDTH'(LANE_MASK_H)) << lane_shift;
        merged = (dm_rd_data & ~wmask) | ((req_wdata << lane_shift) & wmask);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Capture load result, error flag and pending RMW word on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            merge_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            merge_q <= merged;
            addr_q  <= word_addr;
            rdata_q <= (!req_we && !bad) ? load_data : '0;
            err_q   <= bad;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = do_rmw ? RMW_WR : RESP;
            RMW_WR:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; writes are suppressed while reset is held so an aborted RMW never lands.
    always_comb begin
        req_ready  = (state == IDLE);
        dm_addr    = (state == RMW_WR) ? addr_q  : word_addr;
        dm_wr_data = (state == RMW_WR) ? merge_q : req_wdata;
        dm_wr_en   = rst_n && (do_sw || (state == RMW_WR));
        rsp_valid  = (state == RESP);
        rsp_rdata  = (state == RESP) ? rdata_q : '0;
        rsp_err    = (state == RESP) && err_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus a random
// request stream compared against a byte-level reference memory model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        dm_wr_en;
    logic [31:0] dm_addr;
    logic [31:0] dm_wr_data;
    logic [31:0] dm_rd_data;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bd_en;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .dm_wr_en   (dm_wr_en),
        .dm_addr    (dm_addr),
        .dm_wr_data (dm_wr_data),
        .dm_rd_data (dm_rd_data),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    assign dm_rd_data = mem[dm_addr[7:2]];

    // Data memory: DUT writes plus a backdoor port for preloading.
    always @(posedge clk) begin
        if (dm_wr_en)
            mem[dm_addr[7:2]] <= dm_wr_data;
        else if (bd_en)
            mem[bd_idx] <= bd_val;
    end

    // Hard stop in case something hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic setWord(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_en  = 1'b1;
        bd_idx = 6'(idx);
        bd_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        bd_en  = 1'b0;
    endtask

    // Reference model: byte-addressed memory semantics of RV32I loads/stores.
    task automatic refAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic exp_err,
                             output logic [31:0] exp_rdata, output int exp_lat, output int exp_wr);
        int          size;
        logic        sgn;
        logic        ok;
        int unsigned a;
        logic [31:0] word;
        logic [31:0] val;
        size = 0;
        sgn  = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        ok = (size != 0) && !(we && f3[2]);
        a  = addr;
        if (ok && (a % size) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            ok = 1'b0;
`else
            a = a - (a % size);
`endif
        end
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        exp_lat   = 1;
        exp_wr    = -1;
        if (!ok) begin
            exp_err = 1'b1;
        end else if (!we) begin
            word = ref_mem[a / 4];
            val  = 32'h0;
            for (int i = 0; i < size; i++)
                val |= ((word >> (8 * ((a % 4) + i))) & 32'hFF) << (8 * i);
            if (sgn && val[8 * size - 1])
                val |= 32'hFFFF_FFFF << (8 * size);
            exp_rdata = val;
        end else begin
            word = ref_mem[a / 4];
            for (int i = 0; i < size; i++) begin
                int b;
                b = int'(a % 4) + i;
                word = (word & ~(32'hFF << (8 * b))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * b));
            end
            ref_mem[a / 4] = word;
            if (size == 4) begin
                exp_wr = 0;
            end else begin
                exp_wr  = 1;
                exp_lat = 2;
            end
        end
    endtask

    // Issue one request and observe four cycles starting at the accept cycle.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wr;
        int          rsp_cnt;
        int          rsp_cyc;
        int          wr_cnt;
        int          wr_cyc;
        refAccess(we, f3, addr, wdata, exp_err, exp_rdata, exp_lat, exp_wr);
        rsp_cnt    = 0;
        rsp_cyc    = -1;
        wr_cnt     = 0;
        wr_cyc     = -1;
        last_rdata = 32'h0;
        last_err   = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            #1;
            if (c == 0)
                checkOutput("ready_at_issue", 32'(req_ready), 32'd1);
            if (dm_wr_en) begin
                wr_cnt++;
                wr_cyc = c;
                checkOutput("wr_addr_aligned", 32'(dm_addr[1:0]), 32'd0);
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc    = c;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
        end
        checkOutput("rsp_count", 32'(rsp_cnt), 32'd1);
        checkOutput("rsp_latency", 32'(rsp_cyc), 32'(exp_lat));
        checkOutput("rsp_err", 32'(last_err), 32'(exp_err));
        checkOutput("rsp_rdata", last_rdata, exp_rdata);
        checkOutput("wr_count", 32'(wr_cnt), (exp_wr < 0) ? 32'd0 : 32'd1);
        checkOutput("wr_cycle", 32'(wr_cyc), 32'(exp_wr));
        checkOutput("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
    endtask

    initial begin
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_wr;
        int          acc [0:2];
        int          idx;
        int          pulses;
        logic        b_we    [0:2];
        logic [2:0]  b_f3    [0:2];
        logic [31:0] b_addr  [0:2];
        logic [31:0] b_wdata [0:2];

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bd_en      = 1'b0;
        bd_idx     = 6'd0;
        bd_val     = 32'h0;

        for (int i = 0; i < 64; i++)
            setWord(i, $urandom);

        // Reset state.
        @(negedge clk);
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_wr_en", 32'(dm_wr_en), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Byte loads with sign and zero extension.
        setWord(4, 32'h8899AABB);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
        checkOutput("lb_0x13", last_rdata, 32'hFFFFFF88);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
        checkOutput("lbu_0x13", last_rdata, 32'h00000088);

        // Byte store via read-modify-write, then read back the word.
        applyStimulus(1'b1, 3'b000, 32'h11, 32'h000000CC);
        checkOutput("sb_word", mem[4], 32'h8899CCBB);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("lw_after_sb", last_rdata, 32'h8899CCBB);

        // Half stores, aligned and misaligned.
        setWord(4, 32'h8899AABB);
        applyStimulus(1'b1, 3'b001, 32'h12, 32'h00001234);
        checkOutput("sh_0x12_word", mem[4], 32'h1234AABB);
        setWord(4, 32'h8899AABB);
        applyStimulus(1'b1, 3'b001, 32'h13, 32'h00001234);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("sh_0x13_word", mem[4], 32'h8899AABB);
        checkOutput("sh_0x13_err", 32'(last_err), 32'd1);
`else
        checkOutput("sh_0x13_word", mem[4], 32'h1234AABB);
        checkOutput("sh_0x13_err", 32'(last_err), 32'd0);
`endif

        // Illegal funct3 load.
        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
        checkOutput("illegal_err", 32'(last_err), 32'd1);
        checkOutput("illegal_rdata", last_rdata, 32'h0);

        // Back-to-back LW, SW, SB with req_valid held high.
        b_we[0] = 1'b0; b_f3[0] = 3'b010; b_addr[0] = 32'h10; b_wdata[0] = 32'h0;
        b_we[1] = 1'b1; b_f3[1] = 3'b010; b_addr[1] = 32'h20; b_wdata[1] = $urandom;
        b_we[2] = 1'b1; b_f3[2] = 3'b000; b_addr[2] = 32'h21; b_wdata[2] = $urandom;
        for (int k = 0; k < 3; k++) begin
            refAccess(b_we[k], b_f3[k], b_addr[k], b_wdata[k], e_err, e_rd, e_lat, e_wr);
            acc[k] = -1;
        end
        idx    = 0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (idx < 3) begin
                req_valid  = 1'b1;
                req_we     = b_we[idx];
                req_funct3 = b_f3[idx];
                req_addr   = b_addr[idx];
                req_wdata  = b_wdata[idx];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (rsp_valid)
                pulses++;
            if (req_valid && req_ready && idx < 3) begin
                acc[idx] = c;
                idx++;
            end
        end
        req_valid = 1'b0;
        checkOutput("b2b_accept0", 32'(acc[0]), 32'd0);
        checkOutput("b2b_accept1", 32'(acc[1]), 32'd2);
        checkOutput("b2b_accept2", 32'(acc[2]), 32'd4);
        checkOutput("b2b_pulses", 32'(pulses), 32'd3);
        checkOutput("b2b_mem8", mem[8], ref_mem[8]);

        // Reset during RMW_WR aborts the store.
        setWord(4, 32'h8899AABB);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h11;
        req_wdata  = 32'h000000CC;
        #1;
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("abort_wr_en", 32'(dm_wr_en), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_wr_en2", 32'(dm_wr_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("abort_ready_after", 32'(req_ready), 32'd1);
        checkOutput("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
        checkOutput("abort_mem", mem[4], 32'h8899AABB);

        // Random request stream.
        for (int n = 0; n < 80; n++)
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          32'($urandom_range(0, 255)), $urandom);

        // Sweep the whole memory for stray writes.
        @(negedge clk);
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width.
REQ-002 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 Ports: one clock, reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
REQ-004 Request side, from EX/MEM:
- req_valid  in  1  request present
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign code
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- req_ready  out  1  request accepted this cycle
REQ-005 Data-memory side:
- dm_wr_en  out  1  word write strobe
- dm_addr  out  ADDR_WIDTH  word-aligned address, low two bits 0
- dm_wr_data  out  DATA_WIDTH  word to write
- dm_rd_data  in  DATA_WIDTH  combinational read of the word at dm_addr
REQ-006 Response side, to MEM/WB:
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  load result after extension
- rsp_err  out  1  misaligned or illegal access

Function
REQ-007 FSM states: IDLE, RMW_WR, RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-009 Load (LB=000, LH=001, LW=010, LBU=100, LHU=101):
- dm_addr driven on the accept cycle.
- Byte/half extracted by addr[1:0] and sign/zero-extended, then registered.
- Transition to RESP; rsp_valid one cycle after accept.
REQ-010 SW (010, we=1): dm_wr_en=1 with req_wdata on the accept cycle, then RESP.
REQ-011 SB/SH (000/001, we=1):
- Accept cycle: read dm_rd_data, merge the byte/half lanes, register the merged word and address, go to RMW_WR.
- RMW_WR: dm_wr_en=1 with the merged word, go to RESP.
- rsp_valid two cycles after accept.
REQ-012 RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata=0 for stores.
REQ-013 Illegal funct3 (011, 110, 111, or store with bit2=1):
- No dm_wr_en.
- rsp_err=1, rsp_rdata=0, rsp_valid one cycle after accept.
REQ-014 Outside accepted-store cycles dm_wr_en SHALL be 0. req_valid is ignored while not in IDLE.
REQ-015 Back-to-back requests: a new request is accepted in the IDLE cycle immediately after RESP. Throughput is one load or SW per 2 cycles, one SB/SH per 3 cycles.

Reset
REQ-016 While rst_n=0 at a clock edge:
- State goes to IDLE.
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Merge and address registers cleared.
- dm_wr_en=0 from the following cycle.
REQ-017 Reset asserted in RMW_WR or RESP SHALL abort the operation: no pending write is issued and no response is produced.

Configuration
REQ-018 Macro LSU_MISALIGN_TRAP_EN selects misalignment handling.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, gives no memory write and rsp_err=1, rsp_rdata=0, rsp_valid one cycle after accept.
- Undefined: low address bits are forced to the access alignment (addr[0] cleared for halves, addr[1:0] cleared for words), the access proceeds normally, and rsp_err is only raised for illegal funct3.

Structure
REQ-019 Shared package lsu_pkg SHALL hold:
- funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
- FSM state typedef
- lane-mask helper constants
REQ-020 Sub-module lsu_load_align (combinational byte/half extraction and extension) SHALL be instantiated once. Store merge stays inline.

Verification
REQ-021 Initialise word 0x10 = 0x8899AABB. LB addr 0x13 -> rsp_valid at accept+1, rsp_rdata=0xFFFFFF88. LBU same address -> 0x00000088.
REQ-022 SB addr 0x11, wdata 0x000000CC -> dm_wr_en only at accept+1 with 0x8899CCBB. rsp_valid at accept+2. A subsequent LW 0x10 returns 0x8899CCBB.
REQ-023 SH addr 0x12, wdata 0x1234 -> word becomes 0x1234AABB. With LSU_MISALIGN_TRAP_EN, SH addr 0x13 -> rsp_err=1 and memory unchanged; without it, word becomes 0x1234AABB.
REQ-024 Hold req_valid=1 continuously with LW, SW, SB -> accepts exactly at cycles 0, 2 and 4 (the SB accepted in the IDLE cycle right after the SW's RESP), and exactly one rsp_valid pulse per request.
REQ-025 Assert rst_n=0 during RMW_WR of an SB -> no dm_wr_en, no rsp_valid, memory unchanged, req_ready=1 after reset is released.
REQ-026 funct3=011 load -> rsp_err=1, rsp_rdata=0, dm_wr_en never asserted.
